led_sched_ctrl: RTL and testbench
=================================

LED_SCHED_CTRL -- requirements
Module: led_sched_ctrl

Interface
REQ-001 Parameter TICK_DIV, default 50000, clock cycles per dwell tick (legal range 2..2^20).
REQ-002 Parameter DWELL_TICKS, default 2000, ticks per mode in auto mode (legal range 1..2^16).
REQ-003 CLK  input  1  single system clock; all state on its rising edge.
REQ-004 RSTn  input  1  asynchronous, active-low reset.
REQ-005 Key_Next  input  1  mode-advance request, asynchronous to CLK (debounced key level).
REQ-006 Auto_En  input  1  high: advance mode automatically every dwell period.
REQ-007 Flash_En  output  1  enable for the flash LED engine.
REQ-008 Run_En  output  1  enable for the running LED engine.
REQ-009 Mode  output  2  current mode: 00 OFF, 01 FLASH, 10 RUN, 11 BOTH.
REQ-010 Mode_Change  output  1  one-cycle pulse on entry to a new mode.

Function
REQ-011 FSM states are OFF, FLASH, RUN and BOTH; advance order is OFF->FLASH->RUN->BOTH->FLASH, and OFF is entered only by reset.
REQ-012 Key_Next SHALL pass a two-flop synchronizer, followed by a registered rising-edge detector; a level held high produces exactly one advance.
REQ-013 Key latency: Key_Next sampled high at edges E0, E1 and E2 SHALL produce the new Mode after E2.
REQ-014 Prescaler counts 0..TICK_DIV-1 and wraps to 0; tick is asserted in the cycle the count equals TICK_DIV-1.
REQ-015 Dwell counter increments on tick, counting 0..DWELL_TICKS-1; expiry = tick AND dwell==DWELL_TICKS-1 AND Auto_En.
REQ-016 Auto_En low: prescaler and dwell counter held at 0, and no auto advance occurs.
REQ-017 Advance occurs on key edge OR expiry; both in the same cycle SHALL advance exactly one state.
REQ-018 Every advance, including key-initiated, SHALL clear the prescaler and dwell counter to 0 in the same edge.
REQ-019 Flash_En, Run_En and Mode are registered and decoded from the next state, so all update on the same edge as the state: OFF 0/0, FLASH 1/0, RUN 0/1, BOTH 1/1.
REQ-020 Mode_Change SHALL be high for exactly the first cycle in which the new Mode is visible, and low otherwise.
REQ-021 With Auto_En high, each mode SHALL last exactly TICK_DIV*DWELL_TICKS cycles absent key edges.
REQ-022 Auto_En rising mid-mode: the dwell period starts from 0 at that point; the mode does not change immediately.

Reset
REQ-023 RSTn low SHALL immediately force: state OFF, Mode=00, Flash_En=0, Run_En=0, Mode_Change=0, all counters 0, and synchronizer/edge flops 0.
REQ-024 Reset asserted mid-dwell or mid-synchronization SHALL discard any pending advance; after release the block starts in OFF with counters at 0.
REQ-025 A Key_Next held high through reset release SHALL produce one advance after synchronization (edge relative to the cleared flops).

Structure
REQ-026 Mode encodings (OFF/FLASH/RUN/BOTH) SHALL live in a shared header/package, led_pkg, reused by LED engines and top levels.
REQ-027 Prescaler SHALL be a sub-module led_tick_gen (ports CLK, RSTn, Clr, En, Tick) parameterized by TICK_DIV.
REQ-028 Counter widths are derived from parameters with clog2; no truncation at maximum legal values.

Verification (TICK_DIV=4, DWELL_TICKS=3 unless stated)
REQ-029 Reset release, Auto_En=0, no key for 100 cycles -> Mode=00, enables 0/0, Mode_Change never high.
REQ-030 Auto_En=1 from reset release -> modes 01,10,11,01 at 12-cycle intervals, with one Mode_Change pulse at each transition.
REQ-031 Key_Next high for 20 cycles, Auto_En=0 -> exactly one advance to 01, visible after the third sampling edge.
REQ-032 Auto_En=1 with key edge detected in the expiry cycle -> single advance (01->10, not 11), and the next mode lasts a full 12 cycles.
REQ-033 Key advance 5 cycles into a dwell period -> counters cleared, and the next auto advance occurs 12 cycles later.
REQ-034 RSTn pulsed low mid-RUN, asynchronously between edges -> outputs 00/0/0 immediately without waiting for a clock edge, then the REQ-030 sequence restarts.

Source files
------------

// File: rtl/led_pkg.sv
// Shared LED mode encodings and helpers, reused by the LED engines and top levels.
package led_pkg;

   typedef enum logic [1:0] {
      MODE_OFF   = 2'b00,
      MODE_FLASH = 2'b01,
      MODE_RUN   = 2'b10,
      MODE_BOTH  = 2'b11
   } ledMode_t;

   // OFF is only left, never re-entered; BOTH wraps back to FLASH.
   function automatic ledMode_t advanceMode(input ledMode_t cur);
      case (cur)
         MODE_OFF:   return MODE_FLASH;
         MODE_FLASH: return MODE_RUN;
         MODE_RUN:   return MODE_BOTH;
         default:    return MODE_FLASH;
      endcase
   endfunction

   function automatic logic modeFlash(input ledMode_t m);
      return (m == MODE_FLASH) || (m == MODE_BOTH);
   endfunction

   function automatic logic modeRun(input ledMode_t m);
      return (m == MODE_RUN) || (m == MODE_BOTH);
   endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Dwell prescaler: counts 0..TICK_DIV-1 and flags the last count as a tick.
module led_tick_gen #(
   parameter int TICK_DIV = 50000
) (
   input  logic CLK,
   input  logic RSTn,
   input  logic Clr,
   input  logic En,
   output logic Tick
);

   localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

   logic [CW-1:0] r_count;
   logic          w_atLast;

   assign w_atLast = (r_count == LAST);
   assign Tick     = En && w_atLast;

   // Held at zero while disabled so an enable always starts a full period.
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         r_count <= '0;
      end else if (Clr || !En || w_atLast) begin
         r_count <= '0;
      end else begin
         r_count <= r_count + CW'(1);
      end
   end

endmodule

// File: rtl/led_sched_ctrl.sv
// LED mode scheduler: advances OFF/FLASH/RUN/BOTH on a key edge or on dwell expiry.
module led_sched_ctrl
   import led_pkg::*;
#(
   parameter int TICK_DIV    = 50000,
   parameter int DWELL_TICKS = 2000
) (
   input  logic       CLK,
   input  logic       RSTn,
   input  logic       Key_Next,
   input  logic       Auto_En,
   output logic       Flash_En,
   output logic       Run_En,
   output logic [1:0] Mode,
   output logic       Mode_Change
);

   localparam int DW = (DWELL_TICKS > 2) ? $clog2(DWELL_TICKS) : 1;
   localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_TICKS - 1);

   logic          r_keySync1;
   logic          r_keySync2;
   logic          r_keyPrev;
   logic          w_keyEdge;
   logic          w_tick;
   logic          w_expiry;
   logic          w_advance;
   logic [DW-1:0] r_dwell;
   ledMode_t      r_state;
   ledMode_t      w_nextState;
   ledMode_t      r_mode;
   logic          r_flashEn;
   logic          r_runEn;
   logic          r_modeChange;

   // Key is asynchronous: two-flop synchronizer then a previous-level flop for edge detection.
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         r_keySync1 <= 1'b0;
         r_keySync2 <= 1'b0;
         r_keyPrev  <= 1'b0;
      end else begin
         r_keySync1 <= Key_Next;
         r_keySync2 <= r_keySync1;
         r_keyPrev  <= r_keySync2;
      end
   end

   assign w_keyEdge = r_keySync2 && !r_keyPrev;
   assign w_expiry  = w_tick && (r_dwell == DWELL_LAST) && Auto_En;
   assign w_advance = w_keyEdge || w_expiry;

   led_tick_gen #(
      .TICK_DIV (TICK_DIV)
   ) u_tickGen (
      .CLK  (CLK),
      .RSTn (RSTn),
      .Clr  (w_advance),
      .En   (Auto_En),
      .Tick (w_tick)
   );

   // Any advance restarts the dwell period, whichever source caused it.
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         r_dwell <= '0;
      end else if (w_advance || !Auto_En) begin
         r_dwell <= '0;
      end else if (w_tick) begin
         r_dwell <= (r_dwell == DWELL_LAST) ? '0 : r_dwell + DW'(1);
      end
   end

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         r_state <= MODE_OFF;
      end else begin
         r_state <= w_nextState;
      end
   end

   always_comb begin
      w_nextState = r_state;
      if (w_advance) begin
         w_nextState = advanceMode(r_state);
      end
   end

   // Outputs decode the next state so they change on the same edge as the state.
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         r_mode       <= MODE_OFF;
         r_flashEn    <= 1'b0;
         r_runEn      <= 1'b0;
         r_modeChange <= 1'b0;
      end else begin
         r_mode       <= w_nextState;
         r_flashEn    <= modeFlash(w_nextState);
         r_runEn      <= modeRun(w_nextState);
         r_modeChange <= w_advance;
      end
   end

   assign Mode        = r_mode;
   assign Flash_En    = r_flashEn;
   assign Run_En      = r_runEn;
   assign Mode_Change = r_modeChange;

endmodule

// File: tb/tb_led_sched_ctrl.sv
// Self-checking bench for led_sched_ctrl with TICK_DIV=4, DWELL_TICKS=3 (12-cycle dwell).
module tb_led_sched_ctrl;

   logic       clk;
   logic       rstN;
   logic       keyNext;
   logic       autoEn;
   logic       flashEn;
   logic       runEn;
   logic [1:0] mode;
   logic       modeChange;

   int checks;
   int errors;

   typedef struct {
      logic       key;
      logic       autoEn;
      logic [1:0] expMode;
      logic       expChg;
   } vec_t;

   vec_t vecs[19];

   logic [1:0] autoSeq[5];

   led_sched_ctrl #(
      .TICK_DIV    (4),
      .DWELL_TICKS (3)
   ) dut (
      .CLK         (clk),
      .RSTn        (rstN),
      .Key_Next    (keyNext),
      .Auto_En     (autoEn),
      .Flash_En    (flashEn),
      .Run_En      (runEn),
      .Mode        (mode),
      .Mode_Change (modeChange)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Enables are derived from the expected mode: bit 0 flash, bit 1 run.
   task automatic checkOutput(input string name, input logic [1:0] expMode, input logic expChg);
      checks++;
      if (mode !== expMode || flashEn !== expMode[0] || runEn !== expMode[1] || modeChange !== expChg) begin
         errors++;
         $display("[TB] FAIL %s: got Mode=%b Flash=%b Run=%b Chg=%b, expected Mode=%b Flash=%b Run=%b Chg=%b",
                  name, mode, flashEn, runEn, modeChange, expMode, expMode[0], expMode[1], expChg);
      end
   endtask

   task automatic applyStimulus(input logic key, input logic auto);
      keyNext = key;
      autoEn  = auto;
      @(posedge clk);
      #1;
   endtask

   task automatic doReset(input logic key, input logic auto);
      keyNext = key;
      autoEn  = auto;
      rstN    = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset_state", 2'b00, 1'b0);
      @(negedge clk);
      rstN = 1'b1;
   endtask

   // Pure auto-advance run: mode index is n/12, pulse on every 12th edge.
   task automatic runAutoSeq(input string name, input int nEdges);
      for (int n = 1; n <= nEdges; n++) begin
         applyStimulus(1'b0, 1'b1);
         checkOutput(name, autoSeq[n / 12], (n % 12 == 0));
      end
   endtask

   initial begin
      logic [1:0] expMode;
      checks  = 0;
      errors  = 0;
      rstN    = 1'b0;
      keyNext = 1'b0;
      autoEn  = 1'b0;
      autoSeq = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b01};

      // Key-driven walk through all modes, including a single-cycle key pulse and the BOTH->FLASH wrap.
      vecs[0]  = '{1'b0, 1'b0, 2'b00, 1'b0};
      vecs[1]  = '{1'b1, 1'b0, 2'b00, 1'b0};
      vecs[2]  = '{1'b1, 1'b0, 2'b00, 1'b0};
      vecs[3]  = '{1'b1, 1'b0, 2'b01, 1'b1};
      vecs[4]  = '{1'b1, 1'b0, 2'b01, 1'b0};
      vecs[5]  = '{1'b0, 1'b0, 2'b01, 1'b0};
      vecs[6]  = '{1'b0, 1'b0, 2'b01, 1'b0};
      vecs[7]  = '{1'b1, 1'b0, 2'b01, 1'b0};
      vecs[8]  = '{1'b1, 1'b0, 2'b01, 1'b0};
      vecs[9]  = '{1'b0, 1'b0, 2'b10, 1'b1};
      vecs[10] = '{1'b0, 1'b0, 2'b10, 1'b0};
      vecs[11] = '{1'b1, 1'b0, 2'b10, 1'b0};
      vecs[12] = '{1'b1, 1'b0, 2'b10, 1'b0};
      vecs[13] = '{1'b0, 1'b0, 2'b11, 1'b1};
      vecs[14] = '{1'b0, 1'b0, 2'b11, 1'b0};
      vecs[15] = '{1'b1, 1'b0, 2'b11, 1'b0};
      vecs[16] = '{1'b0, 1'b0, 2'b11, 1'b0};
      vecs[17] = '{1'b0, 1'b0, 2'b01, 1'b1};
      vecs[18] = '{1'b0, 1'b0, 2'b01, 1'b0};

      doReset(1'b0, 1'b0);
      for (int i = 0; i < 19; i++) begin
         applyStimulus(vecs[i].key, vecs[i].autoEn);
         checkOutput($sformatf("vec%0d", i), vecs[i].expMode, vecs[i].expChg);
      end

      // Idle after reset with auto disabled: stays OFF, never pulses.
      doReset(1'b0, 1'b0);
      for (int n = 1; n <= 100; n++) begin
         applyStimulus(1'b0, 1'b0);
         checkOutput("idle_off", 2'b00, 1'b0);
      end

      // Key held high through reset release and for 20 cycles: one advance on the third edge.
      doReset(1'b1, 1'b0);
      for (int n = 1; n <= 20; n++) begin
         applyStimulus(1'b1, 1'b0);
         checkOutput("key_held", (n >= 3) ? 2'b01 : 2'b00, (n == 3));
      end

      // Auto sequence, asynchronous reset mid-RUN, then the sequence restarts.
      doReset(1'b0, 1'b1);
      runAutoSeq("auto_seq", 30);
      #2;
      rstN = 1'b0;
      #1;
      checkOutput("async_reset", 2'b00, 1'b0);
      @(negedge clk);
      rstN = 1'b1;
      runAutoSeq("auto_restart", 48);

      // Key edge coincides with the second expiry: single advance FLASH->RUN, then a full dwell.
      doReset(1'b0, 1'b1);
      for (int n = 1; n <= 48; n++) begin
         applyStimulus((n >= 22), 1'b1);
         if (n < 12)      expMode = 2'b00;
         else if (n < 24) expMode = 2'b01;
         else if (n < 36) expMode = 2'b10;
         else if (n < 48) expMode = 2'b11;
         else             expMode = 2'b01;
         checkOutput("key_at_expiry", expMode, (n == 12 || n == 24 || n == 36 || n == 48));
      end

      // Key advance 5 cycles into a dwell restarts the 12-cycle period.
      doReset(1'b0, 1'b1);
      for (int n = 1; n <= 41; n++) begin
         applyStimulus((n == 15 || n == 16), 1'b1);
         if (n < 12)      expMode = 2'b00;
         else if (n < 17) expMode = 2'b01;
         else if (n < 29) expMode = 2'b10;
         else if (n < 41) expMode = 2'b11;
         else             expMode = 2'b01;
         checkOutput("key_mid_dwell", expMode, (n == 12 || n == 17 || n == 29 || n == 41));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
